wb_arbiter: RTL
===============

# wb_arbiter

Writeback arbiter sitting directly upstream of the core register file. It collects results from NSRC functional units over valid/ready handshakes and selects up to NWRITE of them per cycle. The selected results are registered onto the register file write ports (we/waddr/wdata). It guarantees that no two write ports target the same register in one cycle, and it filters out writes to x0.

## Interface
Parameters:
- WIDTH, 64: data width; must match the register file.
- NREGS, 32: number of architectural registers; address width is $clog2(NREGS).
- NSRC, 4: number of result sources (functional units).
- NWRITE, 1: number of register file write ports; 1 ≤ NWRITE ≤ NSRC.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- rstn  in  1  reset; asynchronous, active-low.
- src_valid  in  [NSRC]  source i holds a result.
- src_rd  in  [NSRC][$clog2(NREGS)]  destination register of source i.
- src_data  in  [NSRC][WIDTH]  result of source i.
- src_ready  out  [NSRC]  result of source i accepted this cycle.
- we  out  [NWRITE]  register file write enables.
- waddr  out  [NWRITE][$clog2(NREGS)]  register file write addresses.
- wdata  out  [NWRITE][WIDTH]  register file write data.

## Operation
- Handshake:
  - A transfer occurs on source i when src_valid[i] && src_ready[i] at a rising edge.
  - src_ready is combinational from src_valid, src_rd and the arbitration state.
  - Sources must not make src_valid depend on src_ready.
  - Once src_valid is raised, the source holds it, src_rd and src_data stable until the transfer.
- Selection per cycle:
  - Scan the sources in priority order (see Configuration).
  - Grant each valid source until NWRITE sources with nonzero rd have been granted.
  - Sources with src_rd == 0 are always granted (ready = 1 whenever valid). They consume no write port and never produce we.
  - A source whose nonzero rd equals the rd of an already-granted source in the same cycle is not granted. It waits for a later cycle.
- Output assignment:
  - Granted nonzero-rd sources fill write ports 0..k-1 in scan order.
  - Their rd/data are registered into waddr/wdata, and the matching we bits are set.
  - Unused ports get we = 0; their waddr/wdata hold the previous value.
- No internal buffering beyond the output register. The block never drops or reorders a result from a single source.

## Timing
- Reset (rstn low, asynchronous): we = 0, waddr = 0, wdata = 0, priority pointer = 0. src_ready is forced to 0 while rstn is low.
- Latency: a transfer at edge t drives we/waddr/wdata during cycle t..t+1. The register file captures the value at edge t+1, and it is readable combinationally after that edge.
- Throughput: up to NWRITE nonzero-rd results per cycle, plus any number of x0 results.
- There is no back-pressure from the register file; the output register is rewritten every cycle.
- Boundary cases:
  - All sources idle: we = 0 on the next cycle.
  - More than NWRITE valid: the excess sources see ready = 0 and retry next cycle.
  - Same rd from two sources in one cycle: exactly one is written per cycle.
  - Reset asserted mid-transfer: the in-flight output register is cleared, so the result is lost. Sources are reset by the same rstn.

## Configuration
- WB_RR_EN defined:
  - Round-robin priority. The scan starts at the pointer.
  - After any cycle with at least one nonzero-rd grant, the pointer moves to (last nonzero-rd granted index + 1) mod NSRC.
  - The pointer is unchanged otherwise.
- WB_RR_EN undefined:
  - Fixed priority, source 0 highest.
  - The pointer register is not instantiated.

## Structure
- Shared core package: the register-address typedef (width $clog2(NREGS)) and the data-word typedef, both shared with the register file and the functional units.
- One sub-module, wb_rr_pick: combinational rotate-and-pick that returns grant vectors and port indices, given the valid vector, the rd vector and the start pointer.
- The wb_arbiter top holds the output register and the pointer flop.

## Test plan
- Single result: NWRITE = 1; source 2 valid, rd = 5, data = 0xABCD. Expect src_ready[2] = 1 that cycle; next cycle we[0] = 1, waddr[0] = 5, wdata[0] = 0xABCD.
- x0 filter: source 1 valid, rd = 0. Expect ready = 1 the same cycle and we = 0 the next cycle.
- Contention, round-robin (WB_RR_EN): NWRITE = 1; sources 0..3 continuously valid with rd = 1..4. Expect writes in order rd 1, 2, 3, 4, 1…, one per cycle, so every source is served within 4 cycles.
- Contention, fixed priority (WB_RR_EN off): same stimulus. Expect source 0 granted every cycle and sources 1–3 never ready.
- Same-rd conflict: NWRITE = 2; sources 0 and 1 both valid with rd = 7, data 0x11 and 0x22. Expect the 0x11 write on port 0 in cycle 1 and the 0x22 write in cycle 2, with we[1] = 0 in both cycles.
- Async reset: assert rstn low mid-cycle while we = 1. Expect we, waddr and wdata to go to 0 immediately, without waiting for a clock edge, and src_ready = 0 until rstn is released.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared core package: register-address and data-word types used by the
// register file, the functional units and the writeback arbiter, plus small
// index helpers for the arbiter.
package wb_arbiter_pkg;

  localparam int CORE_WIDTH = 64;
  localparam int CORE_NREGS = 32;
  localparam int CORE_AW    = $clog2(CORE_NREGS);

  typedef logic [CORE_AW-1:0]    reg_addr_t;
  typedef logic [CORE_WIDTH-1:0] data_t;

  // Width of a source index; at least one bit so single-source builds stay legal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // (idx + 1) mod n without a divider.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Purpose: rotate-and-pick for writeback; scans sources from 'start', grants
//   x0 results unconditionally and up to NWRITE distinct nonzero rd results.
// Latency: purely combinational. Backpressure: a source not granted retries.
// Ports: valid/rd per source and start pointer in; grant vector, per-port
//   valid/source index, and the last nonzero-rd granted index out.
module wb_rr_pick
  import wb_arbiter_pkg::*;
#(
  parameter int NSRC   = 4,
  parameter int NWRITE = 1,
  parameter int AW     = 5,
  parameter int SW     = idx_width(NSRC)
) (
  input  logic [NSRC-1:0]           valid,
  input  logic [NSRC-1:0][AW-1:0]   rd,
  input  logic [SW-1:0]             start,
  output logic [NSRC-1:0]           grant,
  output logic [NWRITE-1:0]         port_vld,
  output logic [NWRITE-1:0][SW-1:0] port_src,
  output logic                      any_nz,
  output logic [SW-1:0]             last_src
);

  int   idx;
  int   cnt;
  logic dup;

  always_comb begin
    grant    = '0;
    port_vld = '0;
    port_src = '0;
    any_nz   = 1'b0;
    last_src = '0;
    idx      = 0;
    cnt      = 0;
    dup      = 1'b0;
    for (int k = 0; k < NSRC; k++) begin
      idx = (int'(start) + k) % NSRC;
      if (valid[idx]) begin
        if (rd[idx] == '0) begin
          // x0 results are absorbed here and never occupy a write port.
          grant[idx] = 1'b1;
        end else if (cnt < NWRITE) begin
          // Already-granted x0 sources carry rd 0, so they never match here.
          dup = 1'b0;
          for (int j = 0; j < NSRC; j++) begin
            if (grant[j] && (rd[j] == rd[idx])) dup = 1'b1;
          end
          if (!dup) begin
            grant[idx]    = 1'b1;
            port_vld[cnt] = 1'b1;
            port_src[cnt] = SW'(idx);
            any_nz        = 1'b1;
            last_src      = SW'(idx);
            cnt           = cnt + 1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Purpose: writeback arbiter feeding NWRITE register file write ports from
//   NSRC functional units; no same-rd collisions, x0 writes filtered.
// Latency: one cycle, transfer at edge t appears on we/waddr/wdata after t.
// Backpressure: src_ready low for excess or conflicting sources; they hold.
// Ports: clk, rstn (async active-low); src_valid/src_rd/src_data in,
//   src_ready out; we/waddr/wdata registered outputs to the register file.
// Config: define WB_RR_EN for round-robin priority; otherwise fixed priority
//   with source 0 highest and no pointer register. Requires NWRITE <= NSRC.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int NREGS  = 32,
  parameter int NSRC   = 4,
  parameter int NWRITE = 1
) (
  input  logic                                    clk,
  input  logic                                    rstn,
  input  logic [NSRC-1:0]                         src_valid,
  input  logic [NSRC-1:0][$clog2(NREGS)-1:0]      src_rd,
  input  logic [NSRC-1:0][WIDTH-1:0]              src_data,
  output logic [NSRC-1:0]                         src_ready,
  output logic [NWRITE-1:0]                       we,
  output logic [NWRITE-1:0][$clog2(NREGS)-1:0]    waddr,
  output logic [NWRITE-1:0][WIDTH-1:0]            wdata
);

  localparam int AW = $clog2(NREGS);
  localparam int SW = idx_width(NSRC);

  logic [SW-1:0]             start_ptr;
  logic [NSRC-1:0]           grant;
  logic [NWRITE-1:0]         port_vld;
  logic [NWRITE-1:0][SW-1:0] port_src;
  logic                      any_nz;
  logic [SW-1:0]             last_src;

  wb_rr_pick #(
    .NSRC   (NSRC),
    .NWRITE (NWRITE),
    .AW     (AW),
    .SW     (SW)
  ) u_pick (
    .valid    (src_valid),
    .rd       (src_rd),
    .start    (start_ptr),
    .grant    (grant),
    .port_vld (port_vld),
    .port_src (port_src),
    .any_nz   (any_nz),
    .last_src (last_src)
  );

`ifdef WB_RR_EN
  logic [SW-1:0] ptr_q;

  // Next scan starts just past the last source that won a write port.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= '0;
    end else if (any_nz) begin
      ptr_q <= SW'(wrap_inc(int'(last_src), NSRC));
    end
  end

  assign start_ptr = ptr_q;
`else
  assign start_ptr = '0;
  logic unused_pick;
  assign unused_pick = ^{any_nz, last_src};
`endif

  // Sources share rstn, so ready is held low for the whole reset window.
  assign src_ready = grant & {NSRC{rstn}};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      we    <= '0;
      waddr <= '0;
      wdata <= '0;
    end else begin
      for (int p = 0; p < NWRITE; p++) begin
        we[p] <= port_vld[p];
        // Idle ports keep their last address/data; only we drops.
        if (port_vld[p]) begin
          waddr[p] <= src_rd[port_src[p]];
          wdata[p] <= src_data[port_src[p]];
        end
      end
    end
  end

endmodule
